fft_peak_ctrl: RTL

Frame sequencer and peak tracker for the FFT magnitude-squared stage. Accepts one FFT frame of N complex bins from the FFT output buffer over a valid/ready stream, and issues each bin to the external magnitude-squared unit, which has a fixed 2-cycle latency. It then collects the returned magnitudes and reports the bin index and value of the largest magnitude through a held result handshake. It sits between the FFT core and the spectral-peak consumer, and owns all sequencing of the magnitude unit.

---
 rtl/fft_peak_ctrl_if.sv | 31 +++
 rtl/fft_peak_ctrl.sv | 69 ++++++
 2 files changed

// File: rtl/fft_peak_ctrl_if.sv
// fft_peak_ctrl_if: bin stream, magnitude-unit and peak-result signals of fft_peak_ctrl
interface fft_peak_ctrl_if #(
    parameter int W    = 16,
    parameter int N    = 1024,
    parameter int IDXW = $clog2(N)
);
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_real;
    logic [W-1:0]    in_imag;
    logic            mq_valid;
    logic [W-1:0]    mq_real;
    logic [W-1:0]    mq_imag;
    logic [2*W:0]    mq_mag;
    logic            mq_mag_valid;
    logic            peak_valid;
    logic            peak_ready;
    logic [IDXW-1:0] peak_bin;
    logic [2*W:0]    peak_mag;
    logic            busy;

    modport master (
        input  start, in_valid, in_real, in_imag, mq_mag, mq_mag_valid, peak_ready,
        output in_ready, mq_valid, mq_real, mq_imag, peak_valid, peak_bin, peak_mag, busy
    );
    modport slave (
        output start, in_valid, in_real, in_imag, mq_mag, mq_mag_valid, peak_ready,
        input  in_ready, mq_valid, mq_real, mq_imag, peak_valid, peak_bin, peak_mag, busy
    );
endinterface

// File: rtl/fft_peak_ctrl.sv
// fft_peak_ctrl: feeds one FFT frame to the 2-cycle magnitude unit and tracks the peak bin
module fft_peak_ctrl #(
    parameter int W    = 16,
    parameter int N    = 1024,
    parameter int IDXW = $clog2(N)
) (
    input logic               clk,
    input logic               reset,
    fft_peak_ctrl_if.master   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    state_t          state, state_nx;
    logic [IDXW-1:0] acc_cnt, ret_cnt;
    logic            accept, ret, update;

    assign accept = bus.in_ready && bus.in_valid;
    assign ret    = bus.mq_mag_valid && (state == RUN || state == DRAIN);
    // Returns arrive in bin order, so ret_cnt is the index; strict compare keeps the lower index on ties
    assign update = ret && (ret_cnt == '0 || bus.mq_mag > bus.peak_mag);

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = (state == IDLE  && bus.start)                  ? RUN   :
                   (state == RUN   && accept && acc_cnt == LAST)  ? DRAIN :
                   (state == DRAIN && ret && ret_cnt == LAST)     ? DONE  :
                   (state == DONE  && bus.peak_ready)             ? IDLE  : state;
    end

    always_comb begin
        bus.in_ready   = state == RUN;
        bus.peak_valid = state == DONE;
        bus.busy       = state != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_cnt      <= '0;
            ret_cnt      <= '0;
            bus.mq_valid <= 1'b0;
            bus.mq_real  <= '0;
            bus.mq_imag  <= '0;
            bus.peak_bin <= '0;
            bus.peak_mag <= '0;
        end else begin
            bus.mq_valid <= accept;
            if (state == IDLE && bus.start) begin
                acc_cnt      <= '0;
                ret_cnt      <= '0;
                bus.peak_bin <= '0;
                bus.peak_mag <= '0;
            end
            if (accept) begin
                acc_cnt     <= acc_cnt + 1'b1;
                bus.mq_real <= bus.in_real;
                bus.mq_imag <= bus.in_imag;
            end
            if (ret) ret_cnt <= ret_cnt + 1'b1;
            if (update) begin
                bus.peak_bin <= ret_cnt;
                bus.peak_mag <= bus.mq_mag;
            end
        end
    end
endmodule
